mem_agent_rd_scheduler: RTL and testbench
=========================================

Name: mem_agent_rd_scheduler

Overview:
- AXI read-traffic controller for the DDR memory agent.
- On `start`, issues a programmed number of fixed-length INCR read bursts.
  - Addresses walk linearly from the read base and wrap at the read high bound.
  - Outstanding bursts are capped at the outstanding limit.
- Consumes all R beats and reports busy/done, beat count and error count to the debug/status logic.
- Sits between the agent's control registers and the AXI master AR/R channels.

Parameters:
- ADDR_WIDTH, 32, AXI address width (package AXI_MASTER_ADDR_WIDTH).
- DATA_WIDTH, 64, AXI data width (package AXI_MASTER_DATA_WIDTH).
- OUTSTANDING_MAX, 16, maximum bursts in flight (package AXI_RD_OUTSTANDING_MAX).
- ADDR_BASE, 32'h4000_0000, first burst address and wrap target (package AXI_RD_ADDR_BASE).
- ADDR_HIGH, 32'h8000_0000, exclusive upper address bound (package AXI_RD_ADDR_HIGH).
- BURST_LEN, 16, beats per burst, range 1..256.
- CNT_BITS, 32, width of counters (package DEBUG_COUNTER_BITS).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a run; ignored while busy=1.
- txn_count  in  CNT_BITS  bursts to issue; sampled on an accepted start.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run completes.
- beat_count  out  CNT_BITS  R beats received in the current/last run.
- err_count  out  CNT_BITS  R beats with rresp != 0 in the current/last run.
- m_araddr  out  ADDR_WIDTH  burst address.
- m_arlen  out  8  constant BURST_LEN-1.
- m_arsize  out  3  constant AXI_MASTER_SIZE (3'b011).
- m_arburst  out  2  constant 2'b01 (INCR).
- m_arvalid  out  1  AR valid.
- m_arready  in  1  AR ready.
- m_rvalid  in  1  R valid.
- m_rready  out  1  R ready.
- m_rlast  in  1  last beat of burst.
- m_rresp  in  2  beat response.

Behaviour:
- **Reset values:**
  - busy=0, done=0, beat_count=0, err_count=0, m_arvalid=0, m_araddr=ADDR_BASE.
  - outstanding=0, issued=0, state=IDLE.
  - m_rready=1 (constant 1 at all times, so stray beats are always drained).
- **Handshakes:**
  - An AR handshake is m_arvalid & m_arready.
  - An R handshake is m_rvalid & m_rready.
- **FSM states:** IDLE, ISSUE, DRAIN, DONE.
- **IDLE:**
  - On start, latch target=txn_count.
  - Clear beat_count, err_count and issued; set m_araddr=ADDR_BASE.
  - Next state is ISSUE, or DONE if txn_count==0.
  - busy=1 from the cycle after start.
- **ISSUE:**
  - m_arvalid is registered; it asserts when issued<target and outstanding<OUTSTANDING_MAX.
  - Once asserted, m_arvalid and m_araddr hold stable until the AR handshake (AXI rule).
  - On each AR handshake:
    - issued++.
    - m_araddr += BURST_LEN*8.
    - If the new address >= ADDR_HIGH, m_araddr=ADDR_BASE.
  - After the handshake that makes issued==target, deassert m_arvalid and go to DRAIN.
  - Back-to-back issue is allowed: m_arvalid may stay high across consecutive handshakes.
- **DRAIN:** go to DONE when outstanding==0 and no R handshake is pending this cycle.
- **DONE:** done=1 for exactly one cycle, busy=0, then IDLE. Counters hold their values until the next start.
- **outstanding counter:**
  - +1 on an AR handshake.
  - -1 on an R handshake with m_rlast.
  - Unchanged when both occur in the same cycle.
  - Never exceeds OUTSTANDING_MAX.
  - Decrement at 0 saturates at 0 (stray or post-reset beats).
- **Beat and error counting:**
  - beat_count increments on every R handshake while busy.
  - err_count increments on every R handshake with m_rresp != 0 while busy.
  - Both saturate at all-ones.
- **Counter widths:** issued and target are CNT_BITS; outstanding is $clog2(OUTSTANDING_MAX+1) bits.
- **Mid-operation events:**
  - Reset mid-run aborts immediately to reset values. In-flight R beats are absorbed and not counted.
  - start while busy has no effect.

Decomposition:
- **Shared package:**
  - Add to mem_agent_types: `typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DRAIN, RD_DONE} rd_sched_state_t`.
  - Add localparams AXI_BURST_INCR=2'b01 and AXI_RD_BURST_LEN=16.
  - Reuse the existing AXI_* and DEBUG_COUNTER_BITS constants.
- **Sub-module:** mem_agent_addr_gen (base/high wrap address stepper, advance input, registered address output). It is reused by the write scheduler.

Test Plan:
- **Single burst:** txn_count=1, arready=1, 16 beats with rlast on beat 16 -> one AR at 0x4000_0000, arlen=15, arsize=3, beat_count=16, done pulse once, busy low.
- **Outstanding cap:** txn_count=40, arready=1, no R beats -> exactly 16 AR handshakes, then arvalid stays 0. Releasing 1 burst of beats allows exactly 1 more AR.
- **Address wrap:**
  - Setup: override ADDR_HIGH=0x4000_0200, txn_count=6.
  - Required addresses: 0x4000_0000, 0x80, 0x100, 0x180, then wrap to 0x4000_0000, 0x4000_0080.
- **Backpressure stability:** arready low for 5 cycles while arvalid=1 -> araddr/arvalid unchanged until the handshake.
- **Simultaneous events:** AR handshake and rlast beat in the same cycle with outstanding=3 -> outstanding stays 3. An rresp=2'b10 beat -> err_count=1.
- **Zero count and aborts:**
  - txn_count=0 -> no AR; done the cycle after the IDLE->DONE transition.
  - rst asserted mid-run -> all outputs return to reset values the next cycle.
  - start while busy -> ignored.

Source files
------------

// File: rtl/mem_agent_rd_scheduler_pkg.sv
// Shared types and constants for the DDR memory agent read path.
package mem_agent_rd_scheduler_pkg;

  localparam int          AXI_MASTER_ADDR_WIDTH  = 32;
  localparam int          AXI_MASTER_DATA_WIDTH  = 64;
  localparam logic [2:0]  AXI_MASTER_SIZE        = 3'b011;
  localparam logic [1:0]  AXI_BURST_INCR         = 2'b01;
  localparam int          AXI_RD_OUTSTANDING_MAX = 16;
  localparam logic [31:0] AXI_RD_ADDR_BASE       = 32'h4000_0000;
  localparam logic [31:0] AXI_RD_ADDR_HIGH       = 32'h8000_0000;
  localparam int          AXI_RD_BURST_LEN       = 16;
  localparam int          DEBUG_COUNTER_BITS     = 32;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_DRAIN,
    RD_DONE
  } rd_sched_state_t;

endpackage

// File: rtl/mem_agent_rd_scheduler_addr_gen.sv
// Linear burst address stepper that wraps from ADDR_HIGH back to ADDR_BASE.
module mem_agent_addr_gen #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_HIGH  = '1,
  parameter int                    STEP       = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr
);

  // One extra bit so a step past the top of the address space still compares as >= ADDR_HIGH.
  logic [ADDR_WIDTH:0] addr_inc;

  assign addr_inc = {1'b0, addr} + (ADDR_WIDTH+1)'(STEP);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      addr <= ADDR_BASE;
    end else if (advance) begin
      addr <= (addr_inc >= {1'b0, ADDR_HIGH}) ? ADDR_BASE : addr_inc[ADDR_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mem_agent_rd_scheduler.sv
// AXI read-traffic scheduler: issues fixed-length INCR bursts and counts R beats.
//
// state    | meaning
// RD_IDLE  | waiting for start
// RD_ISSUE | issuing AR bursts, capped by the outstanding limit
// RD_DRAIN | all bursts issued, waiting for the last rlast
// RD_DONE  | one-cycle done pulse
module mem_agent_rd_scheduler
  import mem_agent_rd_scheduler_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = AXI_MASTER_ADDR_WIDTH,
  parameter int                    DATA_WIDTH      = AXI_MASTER_DATA_WIDTH,
  parameter int                    OUTSTANDING_MAX = AXI_RD_OUTSTANDING_MAX,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE       = AXI_RD_ADDR_BASE,
  parameter logic [ADDR_WIDTH-1:0] ADDR_HIGH       = AXI_RD_ADDR_HIGH,
  parameter int                    BURST_LEN       = AXI_RD_BURST_LEN,
  parameter int                    CNT_BITS        = DEBUG_COUNTER_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_BITS-1:0]   txn_count,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_BITS-1:0]   beat_count,
  output logic [CNT_BITS-1:0]   err_count,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic                  m_rlast,
  input  logic [1:0]            m_rresp
);

  localparam int               OUT_W       = $clog2(OUTSTANDING_MAX + 1);
  localparam logic [OUT_W-1:0] OUT_MAX     = OUT_W'(OUTSTANDING_MAX);
  localparam int               BURST_BYTES = BURST_LEN * (DATA_WIDTH / 8);

  rd_sched_state_t     state, state_nxt;
  logic [CNT_BITS-1:0] target, issued, issued_inc;
  logic [OUT_W-1:0]    outstanding, outstanding_nxt;
  logic                arvalid_nxt;
  logic                ar_hs, r_hs, rlast_hs, start_ok;

  assign m_arlen   = 8'(BURST_LEN - 1);
  assign m_arsize  = AXI_MASTER_SIZE;
  assign m_arburst = AXI_BURST_INCR;
  assign m_rready  = 1'b1;

  assign ar_hs      = m_arvalid & m_arready;
  assign r_hs       = m_rvalid & m_rready;
  assign rlast_hs   = r_hs & m_rlast;
  assign start_ok   = (state == RD_IDLE) & start;
  assign issued_inc = issued + 1'b1;
  assign busy       = (state == RD_ISSUE) | (state == RD_DRAIN);
  assign done       = (state == RD_DONE);

  mem_agent_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_BASE  (ADDR_BASE),
    .ADDR_HIGH  (ADDR_HIGH),
    .STEP       (BURST_BYTES)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok),
    .advance (ar_hs),
    .addr    (m_araddr)
  );

  // Stray rlast beats with nothing in flight leave the count at zero.
  always_comb begin
    outstanding_nxt = outstanding;
    if (ar_hs && !rlast_hs) begin
      outstanding_nxt = outstanding + 1'b1;
    end else if (!ar_hs && rlast_hs && (outstanding != '0)) begin
      outstanding_nxt = outstanding - 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    arvalid_nxt = 1'b0;
    case (state)
      RD_IDLE: begin
        if (start) state_nxt = (txn_count == '0) ? RD_DONE : RD_ISSUE;
      end
      RD_ISSUE: begin
        if (ar_hs && (issued_inc == target)) begin
          state_nxt = RD_DRAIN;
        end else if (m_arvalid && !m_arready) begin
          arvalid_nxt = 1'b1;
        end else begin
          arvalid_nxt = ((ar_hs ? issued_inc : issued) < target) && (outstanding_nxt < OUT_MAX);
        end
      end
      RD_DRAIN: begin
        if ((outstanding == '0) && !r_hs) state_nxt = RD_DONE;
      end
      RD_DONE:  state_nxt = RD_IDLE;
      default:  state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RD_IDLE;
      m_arvalid   <= 1'b0;
      outstanding <= '0;
      issued      <= '0;
      target      <= '0;
      beat_count  <= '0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      m_arvalid   <= arvalid_nxt;
      outstanding <= outstanding_nxt;
      if (start_ok) begin
        target     <= txn_count;
        issued     <= '0;
        beat_count <= '0;
        err_count  <= '0;
      end else begin
        if (ar_hs) issued <= issued_inc;
        if (busy && r_hs) begin
          if (~&beat_count) beat_count <= beat_count + 1'b1;
          if ((m_rresp != 2'b00) && ~&err_count) err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_agent_rd_scheduler.sv
// Randomized bench for mem_agent_rd_scheduler with a transaction-level reference model.
module tb_mem_agent_rd_scheduler;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] HIGH = 32'h4000_0200;
  localparam int          BL   = 16;
  localparam int          STEP = BL * 8;
  localparam int          OMAX = 16;
  localparam int unsigned BIG  = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] txn_count = '0;
  logic        busy, done;
  logic [31:0] beat_count, err_count, m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid, m_rready;
  logic        m_arready = 1'b0;
  logic        m_rvalid = 1'b0;
  logic        m_rlast = 1'b0;
  logic [1:0]  m_rresp = 2'b00;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_agent_rd_scheduler #(.ADDR_HIGH(HIGH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .txn_count  (txn_count),
    .busy       (busy),
    .done       (done),
    .beat_count (beat_count),
    .err_count  (err_count),
    .m_araddr   (m_araddr),
    .m_arlen    (m_arlen),
    .m_arsize   (m_arsize),
    .m_arburst  (m_arburst),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready),
    .m_rlast    (m_rlast),
    .m_rresp    (m_rresp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst k of a run sits in slot k mod (number of burst slots below HIGH).
  function automatic logic [31:0] exp_addr(input int unsigned k);
    longint unsigned span, nslots;
    span   = longint'(HIGH) - longint'(BASE);
    nslots = (span + STEP - 1) / STEP;
    return 32'(longint'(BASE) + (longint'(k) % nslots) * STEP);
  endfunction

  // ---------------- reference model + compare (negedge) ----------------
  int          phase = 0;          // 0 idle, 1 running, 2 done cycle
  int unsigned m_target = 0, m_issued = 0, m_out = 0, m_beats = 0, m_errs = 0;
  int unsigned ar_accepted = 0;
  int unsigned sim_hits = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] ar_log[$];

  always @(negedge clk) begin : model
    logic ar_hs, rl;
    int   next_phase;
    check("rready", m_rready, 1);
    check("arlen", m_arlen, 15);
    check("arsize", m_arsize, 3);
    check("arburst", m_arburst, 1);
    check("busy", busy, phase == 1);
    check("done", done, phase == 2);
    check("beat_count", beat_count, m_beats);
    check("err_count", err_count, m_errs);
    check("outstanding", dut.outstanding, m_out);
    if (prev_stall) check("arvalid_hold", m_arvalid, 1);
    if (m_arvalid) begin
      check("arvalid_allowed", (phase == 1) && (m_issued < m_target) && (m_out < OMAX), 1);
      check("araddr", m_araddr, exp_addr(m_issued));
    end

    if (rst) begin
      phase = 0; m_out = 0; m_beats = 0; m_errs = 0;
      m_issued = 0; m_target = 0; prev_stall = 1'b0;
    end else begin
      ar_hs      = m_arvalid && m_arready;
      rl         = m_rvalid && m_rlast;
      prev_stall = m_arvalid && !m_arready;
      if (ar_hs && rl && (m_out == 3)) sim_hits++;
      if ((phase == 1) && m_rvalid) begin
        m_beats++;
        if (m_rresp != 2'b00) m_errs++;
      end
      next_phase = phase;
      case (phase)
        0: if (start) begin
             m_target = txn_count; m_issued = 0; m_beats = 0; m_errs = 0;
             next_phase = (txn_count == 0) ? 2 : 1;
           end
        1: if ((m_issued == m_target) && (m_out == 0) && !m_rvalid) next_phase = 2;
        default: next_phase = 0;
      endcase
      if (ar_hs) begin
        m_issued++;
        ar_accepted++;
        ar_log.push_back(m_araddr);
      end
      if (ar_hs && !rl) m_out++;
      else if (!ar_hs && rl && (m_out > 0)) m_out--;
      phase = next_phase;
    end
  end

  // ---------------- AXI slave driver (posedge + 1) ----------------
  int          ar_mode = 1;        // 0 never ready, 1 always ready, 2 random
  bit          r_rand = 1'b0;
  int          err_mode = 0;       // 0 none, 1 random, 2 single beat at err_at
  int unsigned err_at = 0;
  int unsigned r_allow = BIG;
  int unsigned stray_req = 0;
  int unsigned bursts_done = 0, stray_sent = 0, beat_in_burst = 0, global_beat = 0;
  bit          cur_stray = 1'b0;

  always @(posedge clk) begin
    #1;
    if (m_rvalid) begin
      if (cur_stray) stray_sent++;
      else begin
        global_beat++;
        if (m_rlast) begin bursts_done++; beat_in_burst = 0; end
        else beat_in_burst++;
      end
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; cur_stray = 1'b0;
    if (stray_sent < stray_req) begin
      m_rvalid = 1'b1; m_rlast = 1'b1; cur_stray = 1'b1;
    end else if ((ar_accepted > bursts_done) && (bursts_done < r_allow) &&
                 (!r_rand || ($urandom_range(0, 3) != 0))) begin
      m_rvalid = 1'b1;
      m_rlast  = (beat_in_burst == BL - 1);
      if ((err_mode == 1) && ($urandom_range(0, 7) == 0)) m_rresp = 2'($urandom_range(1, 3));
      else if ((err_mode == 2) && (global_beat == err_at)) m_rresp = 2'b10;
    end
    case (ar_mode)
      0:       m_arready = 1'b0;
      1:       m_arready = 1'b1;
      default: m_arready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // ---------------- directed sequence ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input int unsigned n);
    start = 1'b1; txn_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while ((done !== 1'b1) && (k < budget)) begin tick(); k++; end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_done: done=%b, want 1 within %0d cycles", name, done, budget);
    end
    tick();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          a0, k;
    int unsigned n;
    logic [31:0] wrap_exp [6];
    wrap_exp = '{32'h4000_0000, 32'h4000_0080, 32'h4000_0100,
                 32'h4000_0180, 32'h4000_0000, 32'h4000_0080};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_arvalid", m_arvalid, 0);
    check("reset_araddr", m_araddr, BASE);
    check("reset_beats", beat_count, 0);

    // single burst with one SLVERR beat
    ar_mode = 1; r_rand = 1'b0; err_mode = 2; err_at = global_beat + 4;
    a0 = ar_log.size();
    pulse_start(1);
    wait_done(200, "single");
    check("single_ar_n", ar_log.size() - a0, 1);
    if (ar_log.size() > a0) check("single_addr", ar_log[a0], 32'h4000_0000);
    check("single_beats", beat_count, 16);
    check("single_errs", err_count, 1);
    check("single_busy", busy, 0);

    // address wrap
    err_mode = 0; r_rand = 1'b1;
    a0 = ar_log.size();
    pulse_start(6);
    wait_done(600, "wrap");
    check("wrap_ar_n", ar_log.size() - a0, 6);
    for (int i = 0; i < 6; i++)
      if (a0 + i < ar_log.size()) check("wrap_addr", ar_log[a0 + i], wrap_exp[i]);

    // outstanding cap, then release one burst
    ar_mode = 1; r_rand = 1'b0; r_allow = bursts_done;
    a0 = ar_log.size();
    pulse_start(40);
    repeat (60) tick();
    check("cap_ar_n", ar_log.size() - a0, 16);
    check("cap_arvalid", m_arvalid, 0);
    r_allow = bursts_done + 1;
    repeat (60) tick();
    check("cap_release_ar_n", ar_log.size() - a0, 17);
    check("cap_release_arvalid", m_arvalid, 0);
    r_allow = BIG; r_rand = 1'b1; ar_mode = 2; err_mode = 1;
    wait_done(6000, "cap");
    check("cap_beats", beat_count, 640);

    // AR backpressure
    ar_mode = 0; err_mode = 0;
    pulse_start(2);
    k = 0;
    while ((m_arvalid !== 1'b1) && (k < 20)) begin tick(); k++; end
    check("bp_arvalid_seen", m_arvalid, 1);
    repeat (5) begin
      tick();
      check("bp_arvalid", m_arvalid, 1);
      check("bp_araddr", m_araddr, 32'h4000_0000);
    end
    ar_mode = 2;
    wait_done(400, "bp");
    check("bp_beats", beat_count, 32);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 24);
      ar_mode = 2; r_rand = 1'b1; err_mode = 1;
      pulse_start(n);
      wait_done(4000, "rand_run");
      check("rand_beats", beat_count, n * 16);
    end

    // start while busy is ignored
    pulse_start(10);
    repeat (8) tick();
    pulse_start(3);
    wait_done(3000, "busy_start");
    check("busy_start_beats", beat_count, 160);

    // zero-length run
    a0 = ar_log.size();
    pulse_start(0);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    tick();
    check("zero_done_clear", done, 0);
    check("zero_ar_n", ar_log.size() - a0, 0);

    // reset mid-run; leftover and stray beats are absorbed
    err_mode = 1;
    pulse_start(20);
    repeat (40) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_arvalid", m_arvalid, 0);
    check("rst_araddr", m_araddr, BASE);
    check("rst_beats", beat_count, 0);
    check("rst_errs", err_count, 0);
    stray_req = stray_req + 2;
    k = 0;
    while (((ar_accepted != bursts_done) || (stray_sent != stray_req)) && (k < 2000)) begin
      tick(); k++;
    end
    check("rst_quiet", (ar_accepted == bursts_done) && (stray_sent == stray_req), 1);
    check("rst_stray_beats", beat_count, 0);

    // recovery
    pulse_start(3);
    wait_done(1000, "recover");
    check("recover_beats", beat_count, 48);

    $display("simultaneous AR + rlast at outstanding=3 seen %0d times", sim_hits);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
